// File: rtl/mc_ctrl_fsm.sv
// Purpose : multi-cycle MIPS control FSM (fetch/decode/execute/mem/wb) with retire counter and illegal-opcode flag.
// Latency : R-type 4, I-type 4, lw 5, sw 4, beq 3, j 3, illegal 2 cycles; outputs are registered and valid in the state they belong to.
// Backpress: none; the datapath is assumed to complete every step in one cycle.
// Ports   : clk/rst (sync, active-high); op/funct from IR; zero from ALU;
//           PCWr/IRWr/RFWr/DMWr enables; RegDst/WDSel/ALUSrcA/ALUSrcB/ExtOp/ALUOp/NPCSel selects;
//           state_o debug; instr_done/illegal pulses; instr_cnt retired-instruction count.
module mc_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             PCWr,
    output logic             IRWr,
    output logic             RFWr,
    output logic             DMWr,
    output logic             RegDst,
    output logic             WDSel,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             ExtOp,
    output logic [2:0]       ALUOp,
    output logic [1:0]       NPCSel,
    output logic [3:0]       state_o,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXE_R   = 4'd2,
        S_EXE_I   = 4'd3,
        S_MEM_ADR = 4'd4,
        S_MEM_RD  = 4'd5,
        S_MEM_WR  = 4'd6,
        S_WB_R    = 4'd7,
        S_WB_I    = 4'd8,
        S_WB_LW   = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    typedef struct packed {
        logic       pcwr;
        logic       irwr;
        logic       rfwr;
        logic       dmwr;
        logic       regdst;
        logic       wdsel;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       extop;
        logic [2:0] aluop;
        logic [1:0] npcsel;
        logic       done;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_LUI = 3'b101;

    state_t           r_state;
    state_t           w_next;
    ctrl_t            r_ctl;
    logic [CNT_W-1:0] r_cnt;
    logic             w_rtype_ok;
    logic             w_legal;

    // Control word for a state. Called with the *next* state so the word is
    // registered alongside the state and lands in the cycle it belongs to.
    // op/funct are stable whenever the target state depends on them.
    function automatic ctrl_t f_ctrl(input state_t s, input logic [5:0] s_op, input logic [5:0] s_fn);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:   begin c.irwr = 1'b1; c.pcwr = 1'b1; c.alusrcb = 2'd1; end
            S_DECODE:  begin c.alusrcb = 2'd3; c.extop = 1'b1; end
            S_EXE_R: begin
                c.alusrca = 1'b1;
                case (s_fn)
                    FN_SUBU: c.aluop = ALU_SUB;
                    FN_AND:  c.aluop = ALU_AND;
                    FN_OR:   c.aluop = ALU_OR;
                    FN_SLT:  c.aluop = ALU_SLT;
                    default: c.aluop = ALU_ADD;
                endcase
            end
            S_EXE_I: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'd2;
                case (s_op)
                    OP_ORI:  c.aluop = ALU_OR;
                    OP_LUI:  c.aluop = ALU_LUI;
                    default: begin c.aluop = ALU_ADD; c.extop = 1'b1; end
                endcase
            end
            S_MEM_ADR: begin c.alusrca = 1'b1; c.alusrcb = 2'd2; c.extop = 1'b1; end
            S_WB_R:    begin c.rfwr = 1'b1; c.regdst = 1'b1; c.done = 1'b1; end
            S_WB_I:    begin c.rfwr = 1'b1; c.done = 1'b1; end
            S_WB_LW:   begin c.rfwr = 1'b1; c.wdsel = 1'b1; c.done = 1'b1; end
            S_MEM_WR:  begin c.dmwr = 1'b1; c.done = 1'b1; end
            // PCWr here is driven from zero at the output, not from this word.
            S_BRANCH:  begin c.alusrca = 1'b1; c.aluop = ALU_SUB; c.npcsel = 2'd1; c.done = 1'b1; end
            S_JUMP:    begin c.pcwr = 1'b1; c.npcsel = 2'd2; c.done = 1'b1; end
            default:   c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        w_rtype_ok = (funct == FN_ADDU) || (funct == FN_SUBU) || (funct == FN_AND) ||
                     (funct == FN_OR)   || (funct == FN_SLT);
        w_legal    = ((op == OP_RTYPE) && w_rtype_ok) || (op == OP_ORI) || (op == OP_ADDIU) ||
                     (op == OP_LUI) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_J);
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                if ((op == OP_RTYPE) && w_rtype_ok)                       w_next = S_EXE_R;
                else if (op == OP_ORI || op == OP_ADDIU || op == OP_LUI) w_next = S_EXE_I;
                else if (op == OP_LW || op == OP_SW)                      w_next = S_MEM_ADR;
                else if (op == OP_BEQ)                                    w_next = S_BRANCH;
                else if (op == OP_J)                                      w_next = S_JUMP;
                else                                                      w_next = S_FETCH;
            end
            S_EXE_R:   w_next = S_WB_R;
            S_EXE_I:   w_next = S_WB_I;
            S_MEM_ADR: w_next = (op == OP_LW) ? S_MEM_RD : ((op == OP_SW) ? S_MEM_WR : S_FETCH);
            S_MEM_RD:  w_next = S_WB_LW;
            default:   w_next = S_FETCH; // write-back/terminal states and unused codes 12-15
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_ctl   <= f_ctrl(S_FETCH, op, funct);
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_ctl   <= f_ctrl(w_next, op, funct);
            if (r_ctl.done) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign PCWr       = r_ctl.pcwr | ((r_state == S_BRANCH) & zero);
    assign IRWr       = r_ctl.irwr;
    assign RFWr       = r_ctl.rfwr;
    assign DMWr       = r_ctl.dmwr;
    assign RegDst     = r_ctl.regdst;
    assign WDSel      = r_ctl.wdsel;
    assign ALUSrcA    = r_ctl.alusrca;
    assign ALUSrcB    = r_ctl.alusrcb;
    assign ExtOp      = r_ctl.extop;
    assign ALUOp      = r_ctl.aluop;
    assign NPCSel     = r_ctl.npcsel;
    assign instr_done = r_ctl.done;
    assign state_o    = r_state;
    // The opcode is only known once IR is loaded, so this flag decodes op live in DECODE.
    assign illegal    = (r_state == S_DECODE) & ~w_legal;
    assign instr_cnt  = r_cnt;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       PCWr, IRWr, RFWr, DMWr, RegDst, WDSel, ALUSrcA, ExtOp;
    logic [1:0] ALUSrcB, NPCSel;
    logic [2:0] ALUOp;
    logic [3:0] state_o;
    logic       instr_done, illegal;
    logic [3:0] instr_cnt;

    int checks   = 0;
    int failures = 0;

    mc_ctrl_fsm #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .PCWr(PCWr), .IRWr(IRWr), .RFWr(RFWr), .DMWr(DMWr),
        .RegDst(RegDst), .WDSel(WDSel), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ExtOp(ExtOp), .ALUOp(ALUOp), .NPCSel(NPCSel), .state_o(state_o),
        .instr_done(instr_done), .illegal(illegal), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;
        step(); step();
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_cnt", 32'(instr_cnt), 32'd0);
        rst = 1'b0;

        // FETCH enables
        chk("fetch_state", 32'(state_o), 32'd0);
        chk("fetch_irwr", 32'(IRWr), 32'd1);
        chk("fetch_pcwr", 32'(PCWr), 32'd1);
        chk("fetch_srcb", 32'(ALUSrcB), 32'd1);
        chk("fetch_enables", 32'({RFWr, DMWr, instr_done, illegal, ALUSrcA}), 32'd0);

        // addu: 0,1,2,7,0
        op = 6'b000000; funct = 6'b100001;
        step();
        chk("addu_dec_state", 32'(state_o), 32'd1);
        chk("addu_dec_sel", 32'({ALUSrcA, ALUSrcB, ExtOp, ALUOp}), 32'b0_11_1_000);
        chk("addu_dec_ill", 32'(illegal), 32'd0);
        step();
        chk("addu_exe_state", 32'(state_o), 32'd2);
        chk("addu_exe_sel", 32'({ALUSrcA, ALUSrcB, ALUOp}), 32'b1_00_000);
        chk("addu_exe_rfwr", 32'(RFWr), 32'd0);
        step();
        chk("addu_wb_state", 32'(state_o), 32'd7);
        chk("addu_wb_ctl", 32'({RFWr, RegDst, WDSel, instr_done, DMWr}), 32'b11010);
        step();
        chk("addu_done_state", 32'(state_o), 32'd0);
        chk("addu_cnt", 32'(instr_cnt), 32'd1);

        // slt: ALUOp from funct in EXE_R
        op = 6'b000000; funct = 6'b101010;
        step(); step();
        chk("slt_exe_aluop", 32'(ALUOp), 32'd4);
        step(); step();
        chk("slt_cnt", 32'(instr_cnt), 32'd2);

        // lw: 0,1,4,5,9
        op = 6'b100011; funct = 6'b000000;
        step();
        chk("lw_dec_state", 32'(state_o), 32'd1);
        step();
        chk("lw_adr_state", 32'(state_o), 32'd4);
        chk("lw_adr_sel", 32'({ALUSrcA, ALUSrcB, ExtOp, ALUOp}), 32'b1_10_1_000);
        step();
        chk("lw_rd_state", 32'(state_o), 32'd5);
        chk("lw_rd_en", 32'({PCWr, IRWr, RFWr, DMWr, instr_done}), 32'd0);
        step();
        chk("lw_wb_state", 32'(state_o), 32'd9);
        chk("lw_wb_ctl", 32'({RFWr, RegDst, WDSel, instr_done}), 32'b1011);
        step();
        chk("lw_cnt", 32'(instr_cnt), 32'd3);

        // sw: 0,1,4,6
        op = 6'b101011;
        step();
        chk("sw_dec_rfwr", 32'(RFWr), 32'd0);
        step();
        chk("sw_adr_state", 32'(state_o), 32'd4);
        step();
        chk("sw_wr_state", 32'(state_o), 32'd6);
        chk("sw_wr_ctl", 32'({DMWr, RFWr, instr_done}), 32'b101);
        step();
        chk("sw_end_state", 32'(state_o), 32'd0);
        chk("sw_cnt", 32'(instr_cnt), 32'd4);

        // ori / lui: EXE_I selects, WB_I write
        op = 6'b001101;
        step(); step();
        chk("ori_exe_state", 32'(state_o), 32'd3);
        chk("ori_exe_sel", 32'({ALUSrcA, ALUSrcB, ExtOp, ALUOp}), 32'b1_10_0_011);
        step();
        chk("ori_wb_state", 32'(state_o), 32'd8);
        chk("ori_wb_ctl", 32'({RFWr, RegDst, WDSel, instr_done}), 32'b1001);
        step();
        op = 6'b001111;
        step(); step();
        chk("lui_exe_sel", 32'({ExtOp, ALUOp}), 32'b0_101);
        step(); step();
        chk("ori_lui_cnt", 32'(instr_cnt), 32'd6);

        // beq taken: 0,1,10
        op = 6'b000100; zero = 1'b1;
        step(); step();
        chk("beq1_state", 32'(state_o), 32'd10);
        chk("beq1_ctl", 32'({PCWr, NPCSel, ALUOp, instr_done}), 32'b1_01_001_1);
        step();
        chk("beq1_end_state", 32'(state_o), 32'd0);
        // beq not taken
        zero = 1'b0;
        step(); step();
        chk("beq0_state", 32'(state_o), 32'd10);
        chk("beq0_pcwr", 32'(PCWr), 32'd0);
        step();
        chk("beq0_end_state", 32'(state_o), 32'd0);
        chk("beq_cnt", 32'(instr_cnt), 32'd8);

        // illegal opcode: 0,1,0
        op = 6'b111111;
        step();
        chk("ill_dec_state", 32'(state_o), 32'd1);
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_dec_wr", 32'({RFWr, DMWr, instr_done}), 32'd0);
        step();
        chk("ill_next_state", 32'(state_o), 32'd0);
        chk("ill_flag_clear", 32'(illegal), 32'd0);
        chk("ill_cnt", 32'(instr_cnt), 32'd8);

        // j: 0,1,11
        op = 6'b000010;
        step(); step();
        chk("j_state", 32'(state_o), 32'd11);
        chk("j_ctl", 32'({PCWr, NPCSel, instr_done}), 32'b1_10_1);
        step();
        chk("j_cnt", 32'(instr_cnt), 32'd9);

        // reset during MEM_RD of a lw
        op = 6'b100011;
        step(); step(); step();
        chk("rstlw_rd_state", 32'(state_o), 32'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstlw_state", 32'(state_o), 32'd0);
        chk("rstlw_rfwr", 32'(RFWr), 32'd0);
        chk("rstlw_cnt", 32'(instr_cnt), 32'd0);

        // 16 jumps with a 4-bit counter wrap back to zero
        op = 6'b000010;
        for (int i = 0; i < 16; i++) begin
            step(); step(); step();
            if (i == 14) chk("wrap_cnt15", 32'(instr_cnt), 32'd15);
        end
        chk("wrap_cnt0", 32'(instr_cnt), 32'd0);
        chk("wrap_state", 32'(state_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
